// File: rtl/ika2151_write_sequencer.sv
// Queues host (address, data) register writes and replays each one as an address strobe then a
// data strobe on the IKA2151 bus port. All bus timing is paced by phiM clock-enable ticks.
module ika2151_write_sequencer #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int STROBE_TICKS    = 2,
    parameter int BUSY_TICKS      = 64
) (
    input  logic                       i_EMUCLK,
    input  logic                       i_RST,
    input  logic                       i_phiM_PCEN_n,
    input  logic                       i_REQ_VALID,
    output logic                       o_REQ_READY,
    input  logic [7:0]                 i_REQ_ADDR,
    input  logic [7:0]                 i_REQ_DATA,
    output logic                       o_CS_n,
    output logic                       o_WR_n,
    output logic                       o_RD_n,
    output logic                       o_A0,
    output logic [7:0]                 o_D,
    output logic                       o_BUSY,
    output logic [FIFO_DEPTH_LOG2:0]   o_FIFO_LEVEL,
    output logic [3:0]                 o_DBG_STATE
);
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W     = FIFO_DEPTH_LOG2 + 1;
    localparam int MAX_TICKS = (STROBE_TICKS > BUSY_TICKS) ? STROBE_TICKS : BUSY_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] STRB_LOAD = CNT_W'(STROBE_TICKS - 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_TICKS - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_A_SETUP = 4'd1;
    localparam logic [3:0] S_A_STRB  = 4'd2;
    localparam logic [3:0] S_A_HOLD  = 4'd3;
    localparam logic [3:0] S_GAP     = 4'd4;
    localparam logic [3:0] S_D_SETUP = 4'd5;
    localparam logic [3:0] S_D_STRB  = 4'd6;
    localparam logic [3:0] S_D_HOLD  = 4'd7;
    localparam logic [3:0] S_WAIT    = 4'd8;

    // Handshake: a request is pushed on any EMUCLK edge where i_REQ_VALID and o_REQ_READY are both high.
    logic [7:0]                 mem_addr_q [DEPTH];
    logic [7:0]                 mem_data_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]           level_q, level_d;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d;
    logic [7:0]       d_q, d_d;

    logic tick, push, pop;

    assign tick        = ~i_phiM_PCEN_n;
    assign o_REQ_READY = (level_q != DEPTH_L);
    assign push        = i_REQ_VALID & o_REQ_READY;
    assign pop         = tick & (state_q == S_IDLE) & (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= i_REQ_ADDR;
            mem_data_q[wr_ptr_q] <= i_REQ_DATA;
        end
    end

    // D and A0 only move on edges where CS_n rises or falls, never alongside a WR_n edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        cs_n_d      = cs_n_q;
        wr_n_d      = wr_n_q;
        a0_d        = a0_q;
        d_d         = d_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        state_d     = S_A_SETUP;
                        cs_n_d      = 1'b0;
                        wr_n_d      = 1'b1;
                        a0_d        = 1'b0;
                        d_d         = mem_addr_q[rd_ptr_q];
                        hold_data_d = mem_data_q[rd_ptr_q];
                    end
                end
                S_A_SETUP: begin
                    state_d = S_A_STRB;
                    wr_n_d  = 1'b0;
                    cnt_d   = STRB_LOAD;
                end
                S_A_STRB: begin
                    if (cnt_q == '0) begin
                        state_d = S_A_HOLD;
                        wr_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_A_HOLD: begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                end
                S_GAP: begin
                    state_d = S_D_SETUP;
                    cs_n_d  = 1'b0;
                    a0_d    = 1'b1;
                    d_d     = hold_data_q;
                end
                S_D_SETUP: begin
                    state_d = S_D_STRB;
                    wr_n_d  = 1'b0;
                    cnt_d   = STRB_LOAD;
                end
                S_D_STRB: begin
                    if (cnt_q == '0) begin
                        state_d = S_D_HOLD;
                        wr_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_D_HOLD: begin
                    state_d = S_WAIT;
                    cs_n_d  = 1'b1;
                    a0_d    = 1'b0;
                    cnt_d   = BUSY_LOAD;
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_d = S_IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    a0_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_data_q <= '0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            a0_q        <= a0_d;
            d_q         <= d_d;
        end
    end

    assign o_CS_n       = cs_n_q;
    assign o_WR_n       = wr_n_q;
    assign o_RD_n       = 1'b1;
    assign o_A0         = a0_q;
    assign o_D          = d_q;
    assign o_BUSY       = (level_q != '0) | (state_q != S_IDLE);
    assign o_FIFO_LEVEL = level_q;
    assign o_DBG_STATE  = state_q;
endmodule
